// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper coil sequencer: FSM states,
// the 8-phase unipolar coil table and the per-mode phase increments.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Phase table: bit3 = coil A .. bit0 = coil D.
    // Even phases energise one coil; odd phases energise two.
    localparam logic [3:0] COIL_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    localparam logic [2:0] HALF_INC = 3'd1;
    localparam logic [2:0] FULL_INC = 3'd2;

    // The 3-bit index wraps modulo 8 on its own, so no explicit wrap logic is needed.
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       fwd,
                                            input logic       half);
        logic [2:0] inc;
        inc = half ? HALF_INC : FULL_INC;
        return fwd ? (idx + inc) : (idx - inc);
    endfunction

    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        return COIL_TABLE[idx];
    endfunction

endpackage

// File: rtl/stepper_sequencer_rise_detect.sv
// Registered 1-bit rising-edge detector. RST_VAL = 1 means a line that is
// already high when reset is released does not produce an edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = i_D;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_d;
        end
    end

    assign o_Rise = i_D & ~d_q;

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper coil sequencer: steps a 4-coil unipolar pattern on every prescaler
// rising edge. Optional macro STEPPER_IDLE_RELEASE_EN de-energises coils in IDLE.
module stepper_sequencer #(
    parameter int STEPS_W = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Presc,
    input  logic               i_Start,
    input  logic               i_Stop,
    input  logic               i_Dir,
    input  logic               i_Half,
    input  logic [STEPS_W-1:0] i_Steps,
    output logic [3:0]         o_Coils,
    output logic               o_Busy,
    output logic               o_Done
);

    import stepper_pkg::*;

    logic               tick;
    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [STEPS_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;

    rise_detect #(
        .RST_VAL(1'b1)
    ) u_presc_edge (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_Presc),
        .o_Rise(tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        half_d  = half_q;
        case (state_q)
            IDLE: begin
                // Stop beats start; a tick on the accept edge is deliberately dropped.
                if (i_Start && !i_Stop) begin
                    dir_d  = i_Dir;
                    half_d = i_Half;
                    rem_d  = i_Steps;
                    state_d = (i_Steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (i_Stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    idx_d = next_idx(idx_q, dir_q, half_q);
                    rem_d = rem_q - STEPS_W'(1);
                    if (rem_q == STEPS_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
        end
    end

    assign o_Busy = (state_q == RUN);
    assign o_Done = (state_q == DONE);

`ifdef STEPPER_IDLE_RELEASE_EN
    // Phase index is kept while released so the next move resumes in phase.
    assign o_Coils = (state_q == IDLE) ? 4'b0000 : coil_pattern(idx_q);
`else
    assign o_Coils = coil_pattern(idx_q);
`endif

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: directed scenarios plus random
// traffic, compared every cycle against a phase/step-count model.
module tb_stepper_sequencer;

    localparam int STEPS_W = 16;

`ifdef STEPPER_IDLE_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    localparam logic [3:0] PAT [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };
    localparam logic [3:0] T1 [10] = '{
        4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011,
        4'b0001, 4'b1001, 4'b1000, 4'b1100, 4'b0100
    };
    localparam logic [3:0] T2 [3] = '{4'b1001, 4'b0011, 4'b0110};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               presc = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               dir = 1'b0;
    logic               half = 1'b0;
    logic [STEPS_W-1:0] steps = '0;
    logic [3:0]         coils;
    logic               busy;
    logic               done;

    stepper_sequencer #(
        .STEPS_W(STEPS_W)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .i_Presc(presc),
        .i_Start(start),
        .i_Stop (stop),
        .i_Dir  (dir),
        .i_Half (half),
        .i_Steps(steps),
        .o_Coils(coils),
        .o_Busy (busy),
        .o_Done (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = stopped, 1 = moving, 2 = finished pulse.
    int m_mode = 0;
    int m_idx  = 0;
    int m_rem  = 0;
    int m_inc  = 1;
    bit m_fwd  = 1'b0;
    bit m_prev = 1'b1;
    bit m_tick = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_idx  = 0;
            m_rem  = 0;
            m_prev = 1'b1;
        end else begin
            m_tick = presc && !m_prev;
            m_prev = presc;
            case (m_mode)
                0: if (start && !stop) begin
                    m_fwd  = dir;
                    m_inc  = half ? 1 : 2;
                    m_rem  = int'(steps);
                    m_mode = (steps == 0) ? 2 : 1;
                end
                1: if (stop) begin
                    m_mode = 0;
                end else if (m_tick) begin
                    m_idx = (m_idx + (m_fwd ? m_inc : 8 - m_inc)) % 8;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    function automatic logic [3:0] exp_coils();
        if (REL && m_mode == 0) return 4'b0000;
        return PAT[m_idx];
    endfunction

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("coils", coils, exp_coils());
            chk("busy", busy, m_mode == 1);
            chk("done", done, m_mode == 2);
        end
    end

    // Stimulus helpers
    int         cnt = 0;
    bit         auto_p = 1'b1;
    bit         p_rose = 1'b0;
    logic [3:0] seen [$];
    bit         rec_first = 1'b1;
    logic [3:0] rec_prev = 4'b0;

    task automatic tick_clk();
        logic old;
        @(negedge clk);
        #1;
        if (busy || done) begin
            if (rec_first) begin
                rec_prev  = coils;
                rec_first = 1'b0;
            end else if (coils !== rec_prev) begin
                seen.push_back(coils);
                rec_prev = coils;
            end
        end
        cnt++;
        old = presc;
        if (auto_p) presc = ((cnt % 10) < 5);
        p_rose = presc && !old;
    endtask

    task automatic start_move(input logic d, input logic h, input int n);
        dir   = d;
        half  = h;
        steps = STEPS_W'(n);
        start = 1'b1;
        seen.delete();
        rec_first = 1'b1;
        tick_clk();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick_clk();
            n++;
        end
        chk({nm, "_timeout"}, n < budget, 1'b1);
        tick_clk();
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1;
        tick_clk();
        chk_en = 1'b1;
        tick_clk();
        rst = 1'b0;
        tick_clk();
        chk("rst_coils", coils, REL ? 4'b0000 : 4'b1000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // Half-step forward, 10 steps from phase 0
        start_move(1'b1, 1'b1, 10);
        wait_done("t1", 300);
        chk("t1_nsteps", seen.size(), 10);
        for (int i = 0; i < 10 && i < seen.size(); i++) chk("t1_pat", seen[i], T1[i]);
        chk("t1_model_idx", m_idx, 2);

        // Back to phase 1, then full-step reverse across the wrap
        start_move(1'b0, 1'b1, 1);
        wait_done("t2a", 100);
        chk("t2_model_idx1", m_idx, 1);
        start_move(1'b0, 1'b0, 3);
        wait_done("t2", 200);
        chk("t2_nsteps", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("t2_pat", seen[i], T2[i]);

        // Zero-step move
        start_move(1'b1, 1'b1, 0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_coils", coils, 4'b0110);
        tick_clk();

        // Stop coinciding with the fifth tick
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        tick_clk();
        start_move(1'b1, 1'b1, 20);
        for (int i = 0; i < 200; i++) begin
            tick_clk();
            if (m_rem == 16 && p_rose) begin
                stop = 1'b1;
                break;
            end
        end
        chk("stop_armed", stop, 1'b1);
        tick_clk();
        stop = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick_clk();
            if (done) done_cnt++;
        end
        chk("stop_no_done", done_cnt, 0);
        chk("stop_model_idx", m_idx, 4);
        chk("stop_coils", coils, REL ? 4'b0000 : 4'b0010);
        start_move(1'b0, 1'b1, 2);
        chk("restart_busy", busy, 1'b1);
        wait_done("restart", 100);

        // Reset mid-move, then presc held high through reset release
        start_move(1'b1, 1'b0, 10);
        repeat (25) tick_clk();
        auto_p = 1'b0;
        presc  = 1'b1;
        rst    = 1'b1;
        tick_clk();
        chk("rm_coils", coils, REL ? 4'b0000 : 4'b1000);
        chk("rm_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) tick_clk();
        start_move(1'b1, 1'b1, 3);
        repeat (20) tick_clk();
        chk("glitch_coils", coils, 4'b1000);
        chk("glitch_busy", busy, 1'b1);
        presc = 1'b0;
        repeat (5) tick_clk();
        presc = 1'b1;
        repeat (50) tick_clk();
        presc = 1'b0;
        repeat (5) tick_clk();
        chk("wide_one_step", coils, 4'b1100);
        chk("wide_busy", busy, 1'b1);
        chk("wide_model_rem", m_rem, 2);
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        tick_clk();
        auto_p = 1'b1;

        // Start during RUN must be ignored
        start_move(1'b1, 1'b1, 10);
        repeat (30) tick_clk();
        steps = STEPS_W'(99);
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        wait_done("ign", 400);
        chk("ign_nsteps", seen.size(), 10);
        chk("ign_model_idx", m_idx, 3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            dir   = $urandom_range(0, 1);
            half  = $urandom_range(0, 1);
            steps = STEPS_W'($urandom_range(0, 12));
            rst   = ($urandom_range(0, 799) == 0);
            tick_clk();
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        repeat (3) tick_clk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
